// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives the PC stream into a variable-latency instruction
// memory and buffers returned words in a prefetch queue that feeds the decoder.
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imReqValid,
    output logic [31:0] imReqAddr,
    input  logic        imReqReady,
    input  logic        imRespValid,
    input  logic [31:0] imRespData,
    input  logic        redirectValid,
    input  logic [31:0] redirectAddr,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic [31:0] instrPcInc,
    input  logic        instrReady
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic MODE_IDLE = 1'b0;
    localparam logic MODE_RUN  = 1'b1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = 1;
    localparam logic [AW-1:0] ONE_P   = 1;

    logic          r_mode;
    logic [31:0]   r_fetchPc;
    logic [31:0]   r_qPc   [DEPTH];
    logic [31:0]   r_qWord [DEPTH];
    logic [31:0]   r_pend  [DEPTH];
    logic [AW-1:0] r_rdPtr, r_wrPtr, r_pendRd, r_pendWr;
    logic [CW-1:0] r_count, r_outst, r_drop;

    logic          w_accept, w_resp, w_push, w_pop;
    logic [CW:0]   w_inflight;
    logic          w_unused_addr_lo;

    // Credits: queued words plus in-flight requests never exceed the queue depth.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
    assign imReqValid = (r_mode == MODE_RUN) && !redirectValid && (w_inflight < DEPTH_W);
    assign imReqAddr  = r_fetchPc;
    assign w_accept   = imReqValid && imReqReady;
    assign w_resp     = imRespValid && (r_outst != '0);
    assign w_push     = w_resp && (r_drop == '0) && !redirectValid;
    assign instrValid = (r_count != '0);
    assign w_pop      = instrValid && instrReady;

    assign instr      = r_qWord[r_rdPtr];
    assign instrPc    = r_qPc[r_rdPtr];
    assign instrPcInc = instrPc + 32'd4;

    assign w_unused_addr_lo = ^redirectAddr[1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mode    <= MODE_IDLE;
            r_fetchPc <= RESET_PC;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_pendRd  <= '0;
            r_pendWr  <= '0;
            r_count   <= '0;
            r_outst   <= '0;
            r_drop    <= '0;
        end else begin
            r_mode  <= MODE_RUN;
            r_outst <= r_outst + CW'(w_accept) - CW'(w_resp);
            if (w_resp)
                r_pendRd <= r_pendRd + ONE_P;
            if (w_accept)
                r_pendWr <= r_pendWr + ONE_P;
            if (redirectValid) begin
                // Everything still in flight belongs to the old stream and must be discarded.
                r_fetchPc <= {redirectAddr[31:2], 2'b00};
                r_drop    <= r_outst - CW'(w_resp);
                r_count   <= '0;
                r_rdPtr   <= '0;
                r_wrPtr   <= '0;
            end else begin
                if (w_accept)
                    r_fetchPc <= r_fetchPc + 32'd4;
                if (w_resp && (r_drop != '0))
                    r_drop <= r_drop - ONE_C;
                if (w_push)
                    r_wrPtr <= r_wrPtr + ONE_P;
                if (w_pop)
                    r_rdPtr <= r_rdPtr + ONE_P;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_qPc[i]   <= '0;
                r_qWord[i] <= '0;
                r_pend[i]  <= '0;
            end
        end else begin
            if (w_accept)
                r_pend[r_pendWr] <= r_fetchPc;
            if (w_push) begin
                r_qPc[r_wrPtr]   <= r_pend[r_pendRd];
                r_qWord[r_wrPtr] <= imRespData;
            end
        end
    end

    a_resp_has_outstanding: assert property (@(posedge clk) disable iff (!rstN)
        imRespValid |-> (r_outst != '0));

endmodule
